vending_core: RTL and testbench

Parametrised vending-machine controller for N items, each with a compile-time price. It accumulates credit from one-cycle coin pulses with saturation and sells the selected item when credit covers the price. It returns change in fixed steps at a programmable tick rate and reports which items are purchasable. It sits between the debounced/one-pulsed button and keyboard decoders and the seven-segment credit display.

---
 rtl/vending_core.sv | 152 +++++++++++++++
 tb/tb_vending_core.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vending_core.sv
// Vending-machine controller: saturating credit, lowest-index purchase, timed change return.
// Define VEND_STOCK_EN to add per-item stock counters and the restock input.
module vending_core #(
    parameter int                            NUM_ITEMS    = 4,
    parameter int                            CREDIT_W     = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES       = {8'd80, 8'd30, 8'd25, 8'd20},
    parameter int                            MAX_CREDIT   = 100,
    parameter int                            REFUND_STEP  = 5,
    parameter int                            REFUND_TICKS = 100_000_000,
    parameter int                            STOCK_W      = 4,
    parameter int                            INIT_STOCK   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin_valid,
    input  logic [CREDIT_W-1:0]  coin_value,
    input  logic [NUM_ITEMS-1:0] buy,
    input  logic                 cancel,
    input  logic                 restock,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_ITEMS-1:0] enable,
    output logic                 busy,
    output logic                 dispense,
    output logic [2:0]           dispense_idx,
    output logic                 change_pulse,
    output logic                 buy_err
);
    localparam int                CNT_W   = (REFUND_TICKS > 2) ? $clog2(REFUND_TICKS) : 1;
    localparam logic [CREDIT_W:0] MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] STEP  = CREDIT_W'(REFUND_STEP);
    localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(REFUND_TICKS - 1);

    typedef enum logic {IDLE, REFUND} state_t;

    state_t               state, state_n;
    logic [CREDIT_W-1:0]  credit_n, price_sel;
    logic [CREDIT_W:0]    sum;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 dispense_n, change_n, err_n;
    logic [2:0]           idx_n, sel;
    logic                 sel_ok, sell;
    logic [NUM_ITEMS-1:0] stock_ok;

    assign busy = (state == REFUND);

    always_comb begin
        enable = '0;
        for (int i = 0; i < NUM_ITEMS; i++)
            enable[i] = (state == IDLE) && (credit >= PRICES[i*CREDIT_W +: CREDIT_W]) && stock_ok[i];
    end

    always_comb begin
        state_n    = state;
        credit_n   = credit;
        cnt_n      = cnt;
        dispense_n = 1'b0;
        idx_n      = dispense_idx;
        change_n   = 1'b0;
        err_n      = 1'b0;
        sell       = 1'b0;
        sel        = 3'd0;
        sel_ok     = 1'b0;
        price_sel  = '0;
        // descending scan leaves the lowest requested index selected
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (buy[i]) begin
                sel       = 3'(i);
                sel_ok    = enable[i];
                price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
            end
        end
        sum = {1'b0, credit} + {1'b0, coin_value};
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (|buy) begin
                    if (sel_ok) begin
                        sell       = 1'b1;
                        credit_n   = credit - price_sel;
                        dispense_n = 1'b1;
                        idx_n      = sel;
                        if (credit_n != '0) state_n = REFUND;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (coin_valid) begin
                    credit_n = (sum > MAX_C) ? MAX_C[CREDIT_W-1:0] : sum[CREDIT_W-1:0];
                end else if (cancel && credit != '0) begin
                    state_n = REFUND;
                end
            end
            REFUND: begin
                err_n = |buy;
                if (cnt == CNT_TOP) begin
                    cnt_n    = '0;
                    change_n = 1'b1;
                    credit_n = (credit > STEP) ? credit - STEP : '0;
                    if (credit_n == '0) state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= '0;
            cnt          <= '0;
            dispense     <= 1'b0;
            dispense_idx <= 3'd0;
            change_pulse <= 1'b0;
            buy_err      <= 1'b0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            cnt          <= cnt_n;
            dispense     <= dispense_n;
            dispense_idx <= idx_n;
            change_pulse <= change_n;
            buy_err      <= err_n;
        end
    end

`ifdef VEND_STOCK_EN
    logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock;

    // restock overrides a same-cycle sale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stock <= {NUM_ITEMS{STOCK_W'(INIT_STOCK)}};
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (restock)                   stock[i] <= STOCK_W'(INIT_STOCK);
                else if (sell && sel == 3'(i)) stock[i] <= stock[i] - 1'b1;
            end
        end
    end

    always_comb begin
        stock_ok = '0;
        for (int i = 0; i < NUM_ITEMS; i++) stock_ok[i] = |stock[i];
    end
`else
    logic unused_stock;
    assign stock_ok     = '1;
    assign unused_stock = ^{restock, sell, STOCK_W[0], INIT_STOCK[0]};
`endif

endmodule

// File: tb/tb_vending_core.sv
// Randomized + directed bench for vending_core against a cycle-level reference model.
module tb_vending_core;
    localparam int RT = 4;
`ifdef VEND_STOCK_EN
    localparam bit STOCK = 1'b1;
`else
    localparam bit STOCK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_value = '0;
    logic [3:0] buy = '0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic [7:0] credit;
    logic [3:0] enable;
    logic       busy, dispense, change_pulse, buy_err;
    logic [2:0] dispense_idx;

    int checks = 0;
    int failures = 0;

    // reference model state
    int prices[4] = '{20, 25, 30, 80};
    int m_credit, m_wait, m_stock[4], m_idx;
    bit m_ref, e_disp, e_chg, e_err;

    vending_core #(.REFUND_TICKS(RT)) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
        .buy(buy), .cancel(cancel), .restock(restock), .credit(credit),
        .enable(enable), .busy(busy), .dispense(dispense), .dispense_idx(dispense_idx),
        .change_pulse(change_pulse), .buy_err(buy_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_enable();
        int e = 0;
        for (int i = 0; i < 4; i++)
            if (!m_ref && m_credit >= prices[i] && (!STOCK || m_stock[i] > 0)) e |= (1 << i);
        return e;
    endfunction

    task automatic model_reset();
        m_credit = 0; m_wait = 0; m_ref = 0; m_idx = 0;
        e_disp = 0; e_chg = 0; e_err = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 3;
    endtask

    // one clock: drive inputs, predict, clock, compare
    task automatic step(input bit cv, input int val, input int b, input bit c, input bit rs);
        int sel;
        coin_valid = cv; coin_value = 8'(val); buy = 4'(b); cancel = c; restock = rs;
        check("enable", enable, exp_enable());
        e_disp = 0; e_chg = 0; e_err = 0;
        if (!m_ref) begin
            if (b != 0) begin
                sel = 0;
                while (((b >> sel) & 1) == 0) sel++;
                if (m_credit >= prices[sel] && (!STOCK || m_stock[sel] > 0)) begin
                    m_credit -= prices[sel];
                    m_stock[sel]--;
                    e_disp = 1; m_idx = sel;
                    if (m_credit > 0) begin m_ref = 1; m_wait = RT; end
                end else e_err = 1;
            end else if (cv) begin
                m_credit = (m_credit + val > 100) ? 100 : m_credit + val;
            end else if (c && m_credit > 0) begin
                m_ref = 1; m_wait = RT;
            end
        end else begin
            e_err = (b != 0);
            m_wait--;
            if (m_wait == 0) begin
                m_credit = (m_credit > 5) ? m_credit - 5 : 0;
                e_chg = 1; m_wait = RT;
                if (m_credit == 0) m_ref = 0;
            end
        end
        if (rs) for (int i = 0; i < 4; i++) m_stock[i] = 3;
        @(posedge clk);
        @(negedge clk);
        check("credit", credit, m_credit);
        check("busy", busy, m_ref);
        check("dispense", dispense, e_disp);
        check("change_pulse", change_pulse, e_chg);
        check("buy_err", buy_err, e_err);
        if (e_disp) check("dispense_idx", dispense_idx, m_idx);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic reset_dut();
        #2 rst = 1'b1;
        #1 model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        check("rst_enable", enable, 0);
        check("rst_strobes", {dispense, change_pulse, buy_err}, 0);
        check("rst_idx", dispense_idx, 0);
        @(negedge clk);
        rst = 1'b0;

        // saturation, including a coin whose raw sum exceeds 8 bits
        step(1, 50, 0, 0, 0); step(1, 50, 0, 0, 0); step(1, 10, 0, 0, 0);
        step(1, 200, 0, 0, 0); idle(1);
        check("sat_enable", enable, 4'b1111);

        // sale leaving change
        reset_dut();
        step(1, 30, 0, 0, 0); step(0, 0, 4'b0010, 0, 0); idle(6);

        // rejected buy then lowest-index arbitration, exact credit
        reset_dut();
        step(1, 20, 0, 0, 0); step(0, 0, 4'b1000, 0, 0); step(0, 0, 4'b1001, 0, 0); idle(2);

        // cancel with coin and buy ignored during refund
        reset_dut();
        step(1, 15, 0, 0, 0); step(0, 0, 0, 1, 0); idle(1);
        step(1, 10, 0, 0, 0); step(0, 0, 4'b0001, 0, 0); idle(10);
        step(0, 0, 0, 1, 0); idle(1);

        // stock exhaustion, restock, restock racing a sale
        reset_dut();
        for (int k = 0; k < 3; k++) begin step(1, 20, 0, 0, 0); step(0, 0, 4'b0001, 0, 0); end
        step(1, 20, 0, 0, 0); step(0, 0, 4'b0001, 0, 0);
        step(0, 0, 0, 0, 1); step(0, 0, 4'b0001, 0, 1);
        for (int k = 0; k < 3; k++) begin step(1, 20, 0, 0, 0); step(0, 0, 4'b0001, 0, 0); end
        idle(1);

        // asynchronous reset in the middle of a refund
        reset_dut();
        step(1, 40, 0, 0, 0); step(0, 0, 0, 1, 0); idle(2);
        #2 rst = 1'b1;
        #1 model_reset();
        check("mid_rst_credit", credit, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_strobes", {dispense, change_pulse, buy_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(RT + 1);
        step(1, 20, 0, 0, 0); idle(1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int r, v, b;
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 4))
                0: v = 5; 1: v = 10; 2: v = 25; 3: v = 50;
                default: v = $urandom_range(0, 255);
            endcase
            b = (r < 15) ? $urandom_range(1, 15) : 0;
            step(r >= 15 && r < 50, v, b, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 29) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end
endmodule
